// File: rtl/mem_pkg.sv
// Shared definitions for the external-memory request path: FSM encodings,
// access sizes, port ids, address regions and small decode helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // addr[31:24] selects the chip select on the engine side
  localparam logic [7:0] REGION_CS1 = 8'd0;
  localparam logic [7:0] REGION_CS2 = 8'd1;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == SIZE_HALF) && lsb[0]) || ((size == SIZE_WORD) && (lsb != 2'd0));
  endfunction

  function automatic logic region_bad(input logic [7:0] region, input int unsigned regions);
    return 32'(region) >= regions;
  endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Lane reordering between RISC-V little-endian data and the engine's MSB-first
// byte stream; purely combinational, WRITE selects packing or unpacking.
module mem_lane_format
  import mem_pkg::*;
#(
  parameter bit WRITE = 1'b0
) (
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  generate
    if (WRITE) begin : g_pack
      logic unused_uns;
      assign unused_uns = unsigned_i;

      // byte at addr+k lands at [31-8k -: 8]; lanes past the size are zeroed
      always_comb begin
        data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
        case (size_i)
          SIZE_BYTE: data_o[23:0] = '0;
          SIZE_HALF: data_o[15:0] = '0;
          default:   ;
        endcase
      end
    end else begin : g_unpack
      // first-received byte sits highest in the N-byte field
      always_comb begin
        case (size_i)
          SIZE_BYTE: data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
          SIZE_HALF: data_o = {{16{~unsigned_i & data_i[7]}}, data_i[7:0], data_i[15:8]};
          default:   data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter driving the SPI engine's level start/done handshake.
// Start rises 1 cycle after grant, ready pulses 1 cycle after done; requests wait in IDLE.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_REGIONS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_err,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ready,
  output logic        ls_err,
  output logic [31:0] ls_rdata,
  output logic        mem_start_request,
  output logic [2:0]  mem_num_bytes,
  output logic [31:0] mem_target_address,
  output logic        mem_is_write,
  output logic [31:0] mem_write_value,
  input  logic        mem_request_done,
  input  logic [31:0] mem_target_data
);

  state_e      state_q;
  port_e       last_grant_q, port_q;
  logic [31:0] addr_q, wval_q;
  logic [1:0]  size_q;
  logic [2:0]  nbytes_q;
  logic        we_q, uns_q, start_q;
  logic        if_ready_q, if_err_q, ls_ready_q, ls_err_q;
  logic [31:0] if_data_q, ls_rdata_q;

  port_e       grant_port;
  logic        grant_vld, grant_ls, req_err;
  logic [31:0] req_addr, wfmt, rfmt;
  logic [1:0]  req_size;

  // on a tie the port that lost last time goes first
  assign grant_vld  = if_req | ls_req;
  assign grant_port = (if_req && ls_req) ? ((last_grant_q == PORT_IF) ? PORT_LS : PORT_IF)
                                         : (ls_req ? PORT_LS : PORT_IF);
  assign grant_ls   = (grant_port == PORT_LS);
  assign req_addr   = grant_ls ? ls_addr : if_addr;
  assign req_size   = grant_ls ? ls_size : SIZE_WORD;
  assign req_err    = misaligned(req_size, req_addr[1:0]) || (req_size == 2'd3) ||
                      region_bad(req_addr[31:24], MEM_REGIONS);

  mem_lane_format #(.WRITE(1'b1)) u_wr_fmt (
    .size_i    (ls_size),
    .unsigned_i(1'b1),
    .data_i    (ls_wdata),
    .data_o    (wfmt)
  );

  mem_lane_format #(.WRITE(1'b0)) u_rd_fmt (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_i    (mem_target_data),
    .data_o    (rfmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_IF;
      port_q       <= PORT_IF;
      addr_q       <= '0;
      wval_q       <= '0;
      size_q       <= '0;
      nbytes_q     <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      start_q      <= 1'b0;
      if_ready_q   <= 1'b0;
      if_err_q     <= 1'b0;
      if_data_q    <= '0;
      ls_ready_q   <= 1'b0;
      ls_err_q     <= 1'b0;
      ls_rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            last_grant_q <= grant_port;
            if (req_err) begin
              // rejected without touching the engine-facing registers
              state_q <= ST_RELEASE;
              if (grant_ls) begin
                ls_ready_q <= 1'b1;
                ls_err_q   <= 1'b1;
                ls_rdata_q <= '0;
              end else begin
                if_ready_q <= 1'b1;
                if_err_q   <= 1'b1;
                if_data_q  <= '0;
              end
            end else begin
              state_q  <= ST_BUSY;
              start_q  <= 1'b1;
              port_q   <= grant_port;
              addr_q   <= req_addr;
              size_q   <= req_size;
              nbytes_q <= size_to_bytes(req_size);
              we_q     <= grant_ls & ls_we;
              wval_q   <= (grant_ls && ls_we) ? wfmt : '0;
              uns_q    <= grant_ls ? ls_unsigned : 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mem_request_done) begin
            state_q <= ST_RELEASE;
            start_q <= 1'b0;
            if (port_q == PORT_LS) begin
              ls_ready_q <= 1'b1;
              ls_err_q   <= 1'b0;
              ls_rdata_q <= rfmt;
            end else begin
              if_ready_q <= 1'b1;
              if_err_q   <= 1'b0;
              if_data_q  <= rfmt;
            end
          end
        end
        ST_RELEASE: begin
          state_q    <= ST_IDLE;
          if_ready_q <= 1'b0;
          if_err_q   <= 1'b0;
          ls_ready_q <= 1'b0;
          ls_err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ready           = if_ready_q;
  assign if_err             = if_err_q;
  assign if_data            = if_data_q;
  assign ls_ready           = ls_ready_q;
  assign ls_err             = ls_err_q;
  assign ls_rdata           = ls_rdata_q;
  assign mem_start_request  = start_q;
  assign mem_num_bytes      = nbytes_q;
  assign mem_target_address = addr_q;
  assign mem_is_write       = we_q;
  assign mem_write_value    = wval_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays requester and engine and
// compares every observation against hand-computed values at the falling edge.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_err;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_unsigned, ls_ready, ls_err;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_start_request, mem_is_write, mem_request_done;
  logic [2:0]  mem_num_bytes;
  logic [31:0] mem_target_address, mem_write_value, mem_target_data;

  int checks = 0;
  int errors = 0;
  int gap, n;

  mem_arbiter #(.MEM_REGIONS(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_ready          (if_ready),
    .if_err            (if_err),
    .if_data           (if_data),
    .ls_req            (ls_req),
    .ls_we             (ls_we),
    .ls_size           (ls_size),
    .ls_unsigned       (ls_unsigned),
    .ls_addr           (ls_addr),
    .ls_wdata          (ls_wdata),
    .ls_ready          (ls_ready),
    .ls_err            (ls_err),
    .ls_rdata          (ls_rdata),
    .mem_start_request (mem_start_request),
    .mem_num_bytes     (mem_num_bytes),
    .mem_target_address(mem_target_address),
    .mem_is_write      (mem_is_write),
    .mem_write_value   (mem_write_value),
    .mem_request_done  (mem_request_done),
    .mem_target_data   (mem_target_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic if_issue(input logic [31:0] addr);
    if_addr = addr;
    if_req  = 1'b1;
    tick();
  endtask

  task automatic ls_issue(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    ls_we       = we;
    ls_size     = size;
    ls_unsigned = uns;
    ls_addr     = addr;
    ls_wdata    = wdata;
    ls_req      = 1'b1;
    tick();
  endtask

  task automatic complete(input logic [31:0] data);
    mem_target_data  = data;
    mem_request_done = 1'b1;
    tick();
  endtask

  task automatic release_all();
    if_req           = 1'b0;
    ls_req           = 1'b0;
    mem_request_done = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_size = SIZE_BYTE; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
    mem_request_done = 1'b0; mem_target_data = '0;
    repeat (2) tick();

    check("rst_start", 32'(mem_start_request), 0);
    check("rst_nbytes", 32'(mem_num_bytes), 0);
    check("rst_if_ready", 32'(if_ready), 0);
    check("rst_ls_ready", 32'(ls_ready), 0);
    check("rst_if_data", if_data, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    check("rst_wval", mem_write_value, 0);
    rst = 1'b0;
    tick();

    // both ports held: LS wins the first tie, then grants alternate
    ls_we = 1'b0; ls_size = SIZE_WORD; ls_unsigned = 1'b0;
    ls_addr = 32'h0000_0100; if_addr = 32'h0000_0200;
    ls_req = 1'b1; if_req = 1'b1;
    gap = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!mem_start_request && n < 20) begin
        tick();
        if (!mem_start_request) gap++;
        n++;
      end
      check("tie_start", 32'(mem_start_request), 1);
      check("tie_addr", mem_target_address, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      if (i > 0) check("tie_gap_ge2", 32'(gap >= 2), 1);
      complete(32'h0000_00AA);
      if (i % 2 == 0) begin
        check("tie_ls_ready", 32'(ls_ready), 1);
        check("tie_ls_rdata", ls_rdata, 32'hAA00_0000);
      end else begin
        check("tie_if_ready", 32'(if_ready), 1);
        check("tie_if_data", if_data, 32'hAA00_0000);
      end
      mem_request_done = 1'b0;
      gap = 1;
    end
    release_all();

    // fetch
    if_issue(32'h0000_0010);
    check("if_start", 32'(mem_start_request), 1);
    check("if_nbytes", 32'(mem_num_bytes), 4);
    check("if_addr", mem_target_address, 32'h0000_0010);
    check("if_is_write", 32'(mem_is_write), 0);
    complete(32'h1300_0093);
    check("if_ready", 32'(if_ready), 1);
    check("if_data", if_data, 32'h9300_0013);
    check("if_err", 32'(if_err), 0);
    check("if_release_start", 32'(mem_start_request), 0);
    release_all();
    check("if_ready_pulse", 32'(if_ready), 0);
    check("if_data_hold", if_data, 32'h9300_0013);

    // stores
    ls_issue(1'b1, SIZE_HALF, 1'b0, 32'h0100_0002, 32'h0000_BEEF);
    check("sh_is_write", 32'(mem_is_write), 1);
    check("sh_nbytes", 32'(mem_num_bytes), 2);
    check("sh_wval", mem_write_value, 32'hEFBE_0000);
    check("sh_addr", mem_target_address, 32'h0100_0002);
    complete(32'h0);
    check("sh_ready", 32'(ls_ready), 1);
    release_all();

    ls_issue(1'b1, SIZE_BYTE, 1'b0, 32'h0000_0003, 32'hFFFF_FFA5);
    check("sb_nbytes", 32'(mem_num_bytes), 1);
    check("sb_wval", mem_write_value, 32'hA500_0000);
    complete(32'h0);
    release_all();

    ls_issue(1'b1, SIZE_WORD, 1'b0, 32'h0000_0008, 32'h1122_3344);
    check("sw_wval", mem_write_value, 32'h4433_2211);
    complete(32'h0);
    release_all();

    // loads with extension
    ls_issue(1'b0, SIZE_BYTE, 1'b0, 32'h0000_0021, 32'h0);
    check("lb_nbytes", 32'(mem_num_bytes), 1);
    check("lb_is_write", 32'(mem_is_write), 0);
    check("lb_wval", mem_write_value, 32'h0);
    complete(32'h0000_0080);
    check("lb_ready", 32'(ls_ready), 1);
    check("lb_rdata", ls_rdata, 32'hFFFF_FF80);
    release_all();

    ls_issue(1'b0, SIZE_BYTE, 1'b1, 32'h0000_0021, 32'h0);
    complete(32'h0000_0080);
    check("lbu_rdata", ls_rdata, 32'h0000_0080);
    release_all();

    ls_issue(1'b0, SIZE_HALF, 1'b0, 32'h0000_0004, 32'h0);
    complete(32'h0000_3480);
    check("lh_rdata", ls_rdata, 32'hFFFF_8034);
    release_all();

    // error grants: immediate ready, zero data, engine untouched
    ls_issue(1'b0, SIZE_WORD, 1'b0, 32'h0000_0006, 32'h0);
    check("lw_mis_ready", 32'(ls_ready), 1);
    check("lw_mis_err", 32'(ls_err), 1);
    check("lw_mis_rdata", ls_rdata, 32'h0);
    check("lw_mis_start", 32'(mem_start_request), 0);
    release_all();
    check("lw_mis_ready_off", 32'(ls_ready), 0);
    check("lw_mis_start2", 32'(mem_start_request), 0);

    if_issue(32'h0200_0000);
    check("if_region_ready", 32'(if_ready), 1);
    check("if_region_err", 32'(if_err), 1);
    check("if_region_data", if_data, 32'h0);
    check("if_region_start", 32'(mem_start_request), 0);
    release_all();
    check("if_region_start2", 32'(mem_start_request), 0);

    if_issue(32'h0000_0002);
    check("if_mis_err", 32'(if_err), 1);
    release_all();

    ls_issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
    check("size3_err", 32'(ls_err), 1);
    release_all();

    ls_issue(1'b0, SIZE_HALF, 1'b0, 32'h0000_0041, 32'h0);
    check("lh_mis_err", 32'(ls_err), 1);
    release_all();

    // reset in the middle of a transaction
    if_issue(32'h0000_0040);
    check("rb_start", 32'(mem_start_request), 1);
    #2 rst = 1'b1;
    #1 check("rb_async_drop", 32'(mem_start_request), 0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    if_issue(32'h0000_0040);
    check("ra_start", 32'(mem_start_request), 1);
    check("ra_addr", mem_target_address, 32'h0000_0040);
    complete(32'h1122_3344);
    check("ra_ready", 32'(if_ready), 1);
    check("ra_data", if_data, 32'h4433_2211);
    release_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
